block_mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 35 +++
 rtl/block_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_block_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data block memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W            = 32;
   localparam int BLOCK_W           = 256;
   localparam int BLOCK_OFFSET_BITS = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      SIDE_I = 1'b0,
      SIDE_D = 1'b1
   } side_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin: on a tie the side not granted last wins.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic  clock,
   input  logic  reset,
   input  logic  req_i,
   input  logic  req_d,
   input  logic  grant_en,
   input  side_t grant_side,
   output logic  grant_valid,
   output side_t grant_sel
);

   side_t last_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         last_q <= SIDE_I;
      end else if (grant_en) begin
         last_q <= grant_side;
      end
   end

   always_comb begin
      grant_valid = req_i | req_d;
      grant_sel   = SIDE_I;
      if (req_i && req_d) begin
         grant_sel = (last_q == SIDE_I) ? SIDE_D : SIDE_I;
      end else if (req_d) begin
         grant_sel = SIDE_D;
      end
   end

endmodule

// File: rtl/block_mem_arbiter.sv
// Shares the 256-bit block memory port between the I-side and D-side requesters,
// sequencing each fixed-latency access with a down-counter.
module block_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LATENCY = 4,
   parameter int ADDR_W      = 32,
   parameter int BLOCK_W     = 256
) (
   input  logic               CLOCK,
   input  logic               RESET,
   input  logic               IReq_IN,
   input  logic [ADDR_W-1:0]  IAddr_IN,
   output logic [BLOCK_W-1:0] IBlock_OUT,
   output logic               IAck_OUT,
   output logic               IStall_OUT,
   input  logic               DReadReq_IN,
   input  logic               DWriteReq_IN,
   input  logic [ADDR_W-1:0]  DAddr_IN,
   input  logic [BLOCK_W-1:0] DBlock_IN,
   output logic [BLOCK_W-1:0] DBlock_OUT,
   output logic               DAck_OUT,
   output logic               DStall_OUT,
   output logic [ADDR_W-1:0]  MemAddress_OUT,
   output logic               MemBlockRead_OUT,
   output logic               MemBlockWrite_OUT,
   output logic [BLOCK_W-1:0] MemBlock_OUT,
   input  logic [BLOCK_W-1:0] MemBlock_IN
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1));

   state_t             state_q, state_d;
   side_t              side_q, grant_sel;
   logic               grant_valid, write_q, done, d_req, iack_q, dack_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [ADDR_W-1:0]  addr_q, sel_addr;
   logic [BLOCK_W-1:0] wdata_q, iblock_q, dblock_q;

   assign d_req    = DReadReq_IN | DWriteReq_IN;
   assign done     = (state_q == ACCESS) && (cnt_q == '0);
   assign sel_addr = (grant_sel == SIDE_D) ? DAddr_IN : IAddr_IN;

   rr_arbiter2 u_arb (
      .clock       (CLOCK),
      .reset       (RESET),
      .req_i       (IReq_IN),
      .req_d       (d_req),
      .grant_en    (done),
      .grant_side  (side_q),
      .grant_valid (grant_valid),
      .grant_sel   (grant_sel)
   );

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_valid) state_d = ACCESS;
         ACCESS:  if (cnt_q == '0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A write wins when the D side raises read and write together.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         side_q   <= SIDE_I;
         write_q  <= 1'b0;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         iblock_q <= '0;
         dblock_q <= '0;
         iack_q   <= 1'b0;
         dack_q   <= 1'b0;
      end else begin
         iack_q <= done && (side_q == SIDE_I);
         dack_q <= done && (side_q == SIDE_D);
         if (state_q == IDLE && grant_valid) begin
            side_q  <= grant_sel;
            write_q <= (grant_sel == SIDE_D) && DWriteReq_IN;
            addr_q  <= sel_addr & ALIGN_MASK;
            cnt_q   <= CNT_LOAD;
            if (grant_sel == SIDE_D) begin
               wdata_q <= DBlock_IN;
            end
         end else if (state_q == ACCESS && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (done && !write_q) begin
            if (side_q == SIDE_I) begin
               iblock_q <= MemBlock_IN;
            end else begin
               dblock_q <= MemBlock_IN;
            end
         end
      end
   end

   assign MemBlockRead_OUT  = (state_q == ACCESS) && !write_q;
   assign MemBlockWrite_OUT = (state_q == ACCESS) && write_q;
   assign MemAddress_OUT    = addr_q;
   assign MemBlock_OUT      = wdata_q;
   assign IBlock_OUT        = iblock_q;
   assign DBlock_OUT        = dblock_q;
   assign IAck_OUT          = iack_q;
   assign DAck_OUT          = dack_q;
   assign IStall_OUT        = IReq_IN & ~iack_q;
   assign DStall_OUT        = d_req & ~dack_q;

endmodule

// File: tb/tb_block_mem_arbiter.sv
// Directed bench for block_mem_arbiter: a per-cycle vector table for single
// reads/writes, then hand-written tie, round-robin, reset-abort and latch sequences.
module tb_block_mem_arbiter;

   localparam logic [255:0] PAT_X   = {4{64'hDEAD_BEEF_0123_4567}};
   localparam logic [255:0] PAT_A   = {8{32'hA5A5_5A5A}};
   localparam logic [255:0] PAT_B   = {8{32'hB00B_1E55}};
   localparam logic [255:0] JUNK    = {8{32'h0BAD_F00D}};
   localparam logic [255:0] PAT_ALT = {8{32'h7777_0001}};
   localparam logic [31:0]  IA = 32'h0040_0024, IA_AL = 32'h0040_0020;
   localparam logic [31:0]  DA = 32'h1000_0044, DA_AL = 32'h1000_0040;
   localparam logic [31:0]  IB = 32'h0000_1234, IB_AL = 32'h0000_1220;
   localparam logic [31:0]  DB = 32'h2000_00FF, DB_AL = 32'h2000_00E0;
   localparam logic [31:0]  DC = 32'h3000_0075, DC_AL = 32'h3000_0060;

   logic         clock = 1'b0;
   logic         reset;
   logic         ireq, dread, dwrite;
   logic [31:0]  iaddr, daddr, mem_addr;
   logic [255:0] iblock, dblock_wr, dblock_rd, mem_wdata, mem_rdata;
   logic         iack, istall, dack, dstall, mem_rd, mem_wr;
   int           total = 0;
   int           bad = 0;

   typedef struct {
      logic         ireq, dread, dwrite;
      logic [31:0]  iaddr, daddr;
      logic [255:0] dblock_wr, mem_rdata;
      logic         e_rd, e_wr, e_iack, e_dack, e_istall, e_dstall;
      logic [31:0]  e_addr;
      logic [255:0] e_wdata, e_iblock, e_dblock;
   } vec_t;

   vec_t vecs[$];

   always #5 clock = ~clock;

   block_mem_arbiter #(.MEM_LATENCY(4), .ADDR_W(32), .BLOCK_W(256)) dut (
      .CLOCK             (clock),
      .RESET             (reset),
      .IReq_IN           (ireq),
      .IAddr_IN          (iaddr),
      .IBlock_OUT        (iblock),
      .IAck_OUT          (iack),
      .IStall_OUT        (istall),
      .DReadReq_IN       (dread),
      .DWriteReq_IN      (dwrite),
      .DAddr_IN          (daddr),
      .DBlock_IN         (dblock_wr),
      .DBlock_OUT        (dblock_rd),
      .DAck_OUT          (dack),
      .DStall_OUT        (dstall),
      .MemAddress_OUT    (mem_addr),
      .MemBlockRead_OUT  (mem_rd),
      .MemBlockWrite_OUT (mem_wr),
      .MemBlock_OUT      (mem_wdata),
      .MemBlock_IN       (mem_rdata)
   );

   function automatic logic [255:0] pat(input int c);
      return {8{32'hC0DE_0000 + 32'(c)}};
   endfunction

   function automatic vec_t mk(input logic r, dr, dw, input logic [31:0] ia, da,
                               input logic [255:0] db, md,
                               input logic xr, xw, xia, xda, xis, xds,
                               input logic [31:0] xa, input logic [255:0] xwd, xib, xdb);
      vec_t v;
      v.ireq = r;  v.dread = dr;  v.dwrite = dw;  v.iaddr = ia;  v.daddr = da;
      v.dblock_wr = db;  v.mem_rdata = md;
      v.e_rd = xr;  v.e_wr = xw;  v.e_iack = xia;  v.e_dack = xda;
      v.e_istall = xis;  v.e_dstall = xds;  v.e_addr = xa;
      v.e_wdata = xwd;  v.e_iblock = xib;  v.e_dblock = xdb;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      ireq = v.ireq;  dread = v.dread;  dwrite = v.dwrite;
      iaddr = v.iaddr;  daddr = v.daddr;
      dblock_wr = v.dblock_wr;  mem_rdata = v.mem_rdata;
   endtask

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;  ireq = 1'b0;  dread = 1'b0;  dwrite = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;  ireq = 1'b0;  dread = 1'b0;  dwrite = 1'b0;
      iaddr = '0;  daddr = '0;  dblock_wr = '0;  mem_rdata = JUNK;

      // Reset values
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      checkOutput("rst.rd", mem_rd, 1'b0);
      checkOutput("rst.wr", mem_wr, 1'b0);
      checkOutput("rst.iack", iack, 1'b0);
      checkOutput("rst.dack", dack, 1'b0);
      checkOutput("rst.addr", mem_addr, 32'h0);
      checkOutput("rst.wdata", mem_wdata, 256'h0);
      checkOutput("rst.iblock", iblock, 256'h0);
      checkOutput("rst.dblock", dblock_rd, 256'h0);
      tick();
      reset = 1'b0;

      // I read at cycle 0, then D write at cycle 7
      for (int k = 0; k < 4; k++) begin
         if (k == 0)
            vecs.push_back(mk(1,0,0, IA,0, '0,JUNK, 0,0,0,0,1,0, 32'h0, '0, '0, '0));
         else
            vecs.push_back(mk(1,0,0, IA,0, '0,JUNK, 1,0,0,0,1,0, IA_AL, '0, '0, '0));
      end
      vecs.push_back(mk(1,0,0, IA,0, '0,PAT_X, 1,0,0,0,1,0, IA_AL, '0, '0, '0));
      vecs.push_back(mk(1,0,0, IA,0, '0,JUNK,  0,0,1,0,0,0, IA_AL, '0, PAT_X, '0));
      vecs.push_back(mk(0,0,0, 0,0,  '0,JUNK,  0,0,0,0,0,0, IA_AL, '0, PAT_X, '0));
      vecs.push_back(mk(0,0,1, 0,DA, PAT_A,JUNK, 0,0,0,0,0,1, IA_AL, '0, PAT_X, '0));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(0,0,1, 0,DA, PAT_A,JUNK, 0,1,0,0,0,1, DA_AL, PAT_A, PAT_X, '0));
      vecs.push_back(mk(0,0,1, 0,DA, PAT_A,JUNK, 0,0,0,1,0,0, DA_AL, PAT_A, PAT_X, '0));
      vecs.push_back(mk(0,0,0, 0,0,  '0,JUNK,    0,0,0,0,0,0, DA_AL, PAT_A, PAT_X, '0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         @(negedge clock);
         checkOutput($sformatf("v%0d.rd", i), mem_rd, vecs[i].e_rd);
         checkOutput($sformatf("v%0d.wr", i), mem_wr, vecs[i].e_wr);
         checkOutput($sformatf("v%0d.iack", i), iack, vecs[i].e_iack);
         checkOutput($sformatf("v%0d.dack", i), dack, vecs[i].e_dack);
         checkOutput($sformatf("v%0d.istall", i), istall, vecs[i].e_istall);
         checkOutput($sformatf("v%0d.dstall", i), dstall, vecs[i].e_dstall);
         checkOutput($sformatf("v%0d.addr", i), mem_addr, vecs[i].e_addr);
         checkOutput($sformatf("v%0d.wdata", i), mem_wdata, vecs[i].e_wdata);
         checkOutput($sformatf("v%0d.iblock", i), iblock, vecs[i].e_iblock);
         checkOutput($sformatf("v%0d.dblock", i), dblock_rd, vecs[i].e_dblock);
         tick();
      end

      // Tie after reset: D served first, then I
      doReset();
      iaddr = IB;  daddr = DB;
      for (int c = 0; c <= 12; c++) begin
         ireq = (c <= 11);  dread = (c <= 5);  mem_rdata = pat(c);
         @(negedge clock);
         checkOutput($sformatf("tie%0d.dack", c), dack, (c == 5));
         checkOutput($sformatf("tie%0d.iack", c), iack, (c == 11));
         checkOutput($sformatf("tie%0d.rd", c), mem_rd, ((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
         checkOutput($sformatf("tie%0d.istall", c), istall, (c <= 10));
         checkOutput($sformatf("tie%0d.dstall", c), dstall, (c <= 4));
         if (c >= 1 && c <= 6) checkOutput($sformatf("tie%0d.addr", c), mem_addr, DB_AL);
         if (c >= 7) checkOutput($sformatf("tie%0d.addr", c), mem_addr, IB_AL);
         if (c == 5) checkOutput("tie.dblock", dblock_rd, pat(4));
         if (c == 11) checkOutput("tie.iblock", iblock, pat(10));
         tick();
      end

      // Reset during cycle 2 of an I access aborts it
      doReset();
      ireq = 1'b1;  iaddr = IA;  mem_rdata = JUNK;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;  ireq = 1'b0;
      @(negedge clock);
      checkOutput("abort.rd", mem_rd, 1'b0);
      checkOutput("abort.wr", mem_wr, 1'b0);
      checkOutput("abort.iack", iack, 1'b0);
      checkOutput("abort.iblock", iblock, 256'h0);
      tick();
      iaddr = IB;
      for (int k = 0; k <= 6; k++) begin
         ireq = (k <= 5);  mem_rdata = pat(k);
         @(negedge clock);
         checkOutput($sformatf("rereq%0d.rd", k), mem_rd, (k >= 1 && k <= 4));
         checkOutput($sformatf("rereq%0d.iack", k), iack, (k == 5));
         if (k == 5) checkOutput("rereq.iblock", iblock, pat(4));
         tick();
      end

      // Both sides request continuously: grants must alternate D,I,D,I,D,I
      begin
         int got;
         got = 0;
         doReset();
         ireq = 1'b1;  dread = 1'b1;  iaddr = IB;  daddr = DB;  mem_rdata = PAT_ALT;
         for (int c = 0; c < 60 && got < 6; c++) begin
            @(negedge clock);
            if (iack || dack) begin
               checkOutput($sformatf("alt%0d.dside", got), dack, (got % 2 == 0));
               checkOutput($sformatf("alt%0d.cycle", got), c, 5 + 6 * got);
               got++;
               if (got == 6) begin
                  ireq = 1'b0;  dread = 1'b0;
               end
            end
            tick();
         end
         checkOutput("alt.count", got, 6);
         ireq = 1'b0;  dread = 1'b0;
      end

      // Read+write together, with D inputs changing during ACCESS
      mem_rdata = JUNK;
      for (int k = 0; k <= 6; k++) begin
         dread = (k <= 5);  dwrite = (k <= 5);
         if (k == 0) begin
            daddr = DC;  dblock_wr = PAT_B;
         end else begin
            daddr = 32'hFFFF_FF00 + 32'(k);  dblock_wr = pat(k + 100);
         end
         @(negedge clock);
         checkOutput($sformatf("hold%0d.rd", k), mem_rd, 1'b0);
         checkOutput($sformatf("hold%0d.wr", k), mem_wr, (k >= 1 && k <= 4));
         checkOutput($sformatf("hold%0d.dack", k), dack, (k == 5));
         if (k >= 1 && k <= 5) begin
            checkOutput($sformatf("hold%0d.addr", k), mem_addr, DC_AL);
            checkOutput($sformatf("hold%0d.wdata", k), mem_wdata, PAT_B);
         end
         if (k >= 5) checkOutput($sformatf("hold%0d.dblock", k), dblock_rd, PAT_ALT);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
